// File: rtl/ex_muldiv_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit:
// op encodings, control states, iteration count and operand helpers.
package ex_muldiv_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_RSVD  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_e;

   localparam int unsigned ITER = 32;
   localparam logic [5:0] LAST_STEP = 6'(ITER - 1);

   // magnitude of a signed operand; unsigned ops pass the raw value
   function automatic logic [31:0] mag32(input logic [31:0] v,
                                         input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-to-muldiv bundle: op issue from the pipeline, HI/LO and status back.
interface ex_muldiv_if;
   import ex_muldiv_pkg::*;

   logic        start;
   op_e         op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        cancel;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;
   logic        done;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  hi, lo, busy, stall, done
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output hi, lo, busy, stall, done
   );

endinterface

// File: rtl/ex_muldiv_datapath.sv
// One iteration of unsigned shift-add multiply or restoring divide
// on the {acc_hi, acc_lo} accumulator pair.
module muldiv_datapath (
   input  logic        is_div,
   input  logic [31:0] acc_hi,
   input  logic [31:0] acc_lo,
   input  logic [31:0] mcand,
   output logic [31:0] nxt_hi,
   output logic [31:0] nxt_lo
);

   logic [32:0] sum;
   logic [32:0] shl;

   always_comb begin
      sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 33'd0);
      shl = {acc_hi, acc_lo[31]};
      if (is_div) begin
         // partial remainder < 2*divisor, so the 32-bit difference is exact
         if (shl >= {1'b0, mcand}) begin
            nxt_hi = shl[31:0] - mcand;
            nxt_lo = {acc_lo[30:0], 1'b1};
         end else begin
            nxt_hi = shl[31:0];
            nxt_lo = {acc_lo[30:0], 1'b0};
         end
      end else begin
         nxt_hi = sum[32:1];
         nxt_lo = {sum[0], acc_lo[31:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit with HI/LO registers,
// 32-step unsigned core plus sign pre-negation and post-correction.
module ex_muldiv
   import ex_muldiv_pkg::*;
(
   input logic         clk,
   input logic         reset,
   ex_muldiv_if.slave  bus
);

   state_e      state, state_nxt;
   logic [5:0]  cnt;
   logic [31:0] acc_hi, acc_lo, mcand;
   logic [31:0] nxt_hi, nxt_lo;
   logic [31:0] hi_q, lo_q;
   logic        is_div, neg_p, neg_r, done_q;
   logic        mul_op, div_op, sgn_op, mthi_op, mtlo_op;
   logic        take, launch, fix_wr;
   logic [31:0] mag_a, mag_b;
   logic [63:0] prod, prod_c;
   logic [31:0] q_c, r_c;

   always_comb begin
      mul_op  = 1'b0;
      div_op  = 1'b0;
      sgn_op  = 1'b0;
      mthi_op = 1'b0;
      mtlo_op = 1'b0;
      unique case (1'b1)
         bus.op == OP_MULT:  begin mul_op = 1'b1; sgn_op = 1'b1; end
         bus.op == OP_MULTU: mul_op = 1'b1;
         bus.op == OP_DIV:   begin div_op = 1'b1; sgn_op = 1'b1; end
         bus.op == OP_DIVU:  div_op = 1'b1;
         bus.op == OP_MTHI:  mthi_op = 1'b1;
         bus.op == OP_MTLO:  mtlo_op = 1'b1;
         default: ;
      endcase
   end

   assign take   = (state == S_IDLE) && bus.start && !bus.cancel;
   assign launch = take && (mul_op || div_op);
   assign fix_wr = (state == S_FIX) && !bus.cancel;
   assign mag_a  = mag32(bus.src_a, sgn_op);
   assign mag_b  = mag32(bus.src_b, sgn_op);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (launch) state_nxt = S_RUN;
         S_RUN: begin
            if (bus.cancel)             state_nxt = S_IDLE;
            else if (cnt == LAST_STEP)  state_nxt = S_FIX;
         end
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (state == S_RUN) || (state == S_FIX);
      bus.stall = bus.busy ||
                  (bus.start && (mul_op || div_op) && !bus.cancel);
   end

   muldiv_datapath u_dp (
      .is_div (is_div),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .mcand  (mcand),
      .nxt_hi (nxt_hi),
      .nxt_lo (nxt_lo)
   );

   // divisor goes to mcand for div, multiplicand for mult
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         mcand  <= '0;
         is_div <= 1'b0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (launch) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= div_op ? mag_a : mag_b;
         mcand  <= div_op ? mag_b : mag_a;
         is_div <= div_op;
         neg_p  <= sgn_op && (bus.src_a[31] ^ bus.src_b[31]);
         neg_r  <= sgn_op && bus.src_a[31];
      end else if (state == S_RUN && !bus.cancel) begin
         cnt    <= cnt + 6'd1;
         acc_hi <= nxt_hi;
         acc_lo <= nxt_lo;
      end
   end

   always_comb begin
      prod   = {acc_hi, acc_lo};
      prod_c = neg_p ? (64'd0 - prod) : prod;
      q_c    = (neg_p && mcand != 32'd0) ? (32'd0 - acc_lo) : acc_lo;
      r_c    = neg_r ? (32'd0 - acc_hi) : acc_hi;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= fix_wr;
         if (fix_wr) begin
            hi_q <= is_div ? r_c : prod_c[63:32];
            lo_q <= is_div ? q_c : prod_c[31:0];
         end else if (take && mthi_op) begin
            hi_q <= bus.src_a;
         end else if (take && mtlo_op) begin
            lo_q <= bus.src_a;
         end
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised self-checking bench for ex_muldiv against an arithmetic
// model of HI/LO results, latency, cancel, reset and move ops.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [31:0] exp_hi, exp_lo;

   ex_muldiv_if bus ();

   ex_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(input op_e o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic signed [31:0] q, r;
      sa = $signed(a);
      sb = $signed(b);
      case (o)
         OP_MULT:  return sa * sb;
         OP_MULTU: return {32'd0, a} * {32'd0, b};
         OP_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF)
               return {32'd0, 32'h80000000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         OP_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // present one op, then wait for done; counts busy/stall dropouts
   task automatic issue(input op_e o, input logic [31:0] a,
                        input logic [31:0] b,
                        output int lat, output int bad);
      lat = -1;
      bad = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.src_a = a;
      bus.src_b = b;
      #1;
      if (!bus.stall) bad++;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = OP_NONE;
      for (int j = 0; j < 40; j++) begin
         if (bus.done) begin
            lat = j;
            break;
         end
         if (!bus.busy || !bus.stall) bad++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.hi !== 32'd0) begin
         errors++;
         $display("FAIL reset_hi got %h want 0", bus.hi);
      end
      checks++;
      if (bus.lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_lo got %h want 0", bus.lo);
      end
      checks++;
      if ({bus.busy, bus.stall, bus.done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b want 000",
                  {bus.busy, bus.stall, bus.done});
      end
      reset = 1'b1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
   endtask

   task automatic test_mult_vec;
      int lat, bad;
      issue(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bad);
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL mult_latency got %0d want 33", lat);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL mult_busy_stall dropouts %0d want 0", bad);
      end
      checks++;
      if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
         errors++;
         $display("FAIL mult_result got %h%h want FFFFFFFFFFFFFFEB",
                  bus.hi, bus.lo);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mult_busy_end got %b want 0", bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL mult_done_pulse got %b want 0", bus.done);
      end
      exp_hi = bus.hi;
      exp_lo = bus.lo;
   endtask

   task automatic test_div_vec;
      int lat, bad;
      issue(OP_DIVU, 32'd100, 32'd7, lat, bad);
      checks++;
      if ({bus.hi, bus.lo, lat} !== {32'd2, 32'd14, 32'd33}) begin
         errors++;
         $display("FAIL divu_100_7 got hi %h lo %h lat %0d want 2 e 33",
                  bus.hi, bus.lo, lat);
      end
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bad);
      checks++;
      if ({bus.hi, bus.lo} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
         errors++;
         $display("FAIL div_m7_2 got hi %h lo %h want FFFFFFFF FFFFFFFD",
                  bus.hi, bus.lo);
      end
      exp_hi = bus.hi;
      exp_lo = bus.lo;
   endtask

   task automatic test_div_corner;
      int lat, bad;
      issue(OP_DIV, 32'h1234, 32'd0, lat, bad);
      checks++;
      if ({bus.hi, bus.lo, lat} !== {32'h1234, 32'hFFFFFFFF, 32'd33}) begin
         errors++;
         $display("FAIL div_by_zero got hi %h lo %h lat %0d want 1234 FFFFFFFF 33",
                  bus.hi, bus.lo, lat);
      end
      issue(OP_DIV, 32'hFFFFFF00, 32'd0, lat, bad);
      checks++;
      if ({bus.hi, bus.lo} !== {32'hFFFFFF00, 32'hFFFFFFFF}) begin
         errors++;
         $display("FAIL div_neg_by_zero got hi %h lo %h want FFFFFF00 FFFFFFFF",
                  bus.hi, bus.lo);
      end
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bad);
      checks++;
      if ({bus.hi, bus.lo} !== {32'd0, 32'h80000000}) begin
         errors++;
         $display("FAIL div_overflow got hi %h lo %h want 0 80000000",
                  bus.hi, bus.lo);
      end
      exp_hi = bus.hi;
      exp_lo = bus.lo;
   endtask

   task automatic test_random;
      int lat, bad;
      op_e o;
      logic [31:0] a, b;
      logic [63:0] want;
      for (int i = 0; i < 16; i++) begin
         o = op_e'(3'($urandom_range(1, 4)));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 :
             (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
         want = model(o, a, b);
         issue(o, a, b, lat, bad);
         checks++;
         if ({bus.hi, bus.lo} !== want || lat !== 33 || bad !== 0) begin
            errors++;
            $display("FAIL random op %0d a %h b %h got %h%h lat %0d want %h lat 33",
                     o, a, b, bus.hi, bus.lo, lat, want);
         end
         exp_hi = want[63:32];
         exp_lo = want[31:0];
      end
   endtask

   task automatic test_move;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MTHI;
      bus.src_a = 32'hDEAD;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL mthi_stall got %b want 0", bus.stall);
      end
      @(negedge clk);
      bus.op    = OP_MTLO;
      bus.src_a = 32'hBEEF;
      checks++;
      if ({bus.hi, bus.lo, bus.busy, bus.stall} !== {32'hDEAD, exp_lo, 2'b00}) begin
         errors++;
         $display("FAIL mthi_write got hi %h lo %h busy %b stall %b want DEAD %h 0 0",
                  bus.hi, bus.lo, bus.busy, bus.stall, exp_lo);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = OP_NONE;
      checks++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'hDEAD, 32'hBEEF, 2'b00}) begin
         errors++;
         $display("FAIL mtlo_write got hi %h lo %h busy %b done %b want DEAD BEEF 0 0",
                  bus.hi, bus.lo, bus.busy, bus.done);
      end
      exp_hi = 32'hDEAD;
      exp_lo = 32'hBEEF;
   endtask

   task automatic test_idle_ignore;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      bus.op     = OP_MTHI;
      bus.src_a  = 32'h55AA55AA;
      @(negedge clk);
      bus.op = OP_MULT;
      #1;
      checks++;
      if ({bus.hi, bus.stall} !== {exp_hi, 1'b0}) begin
         errors++;
         $display("FAIL cancel_idle got hi %h stall %b want %h 0",
                  bus.hi, bus.stall, exp_hi);
      end
      @(negedge clk);
      bus.cancel = 1'b0;
      bus.op     = OP_NONE;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL cancel_idle_launch busy %b want 0", bus.busy);
      end
      @(negedge clk);
      bus.op = OP_RSVD;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if ({bus.hi, bus.lo, bus.busy, bus.stall, bus.done} !==
          {exp_hi, exp_lo, 3'b000}) begin
         errors++;
         $display("FAIL none_rsvd got hi %h lo %h flags %b want %h %h 000",
                  bus.hi, bus.lo, {bus.busy, bus.stall, bus.done}, exp_hi, exp_lo);
      end
      bus.op = OP_NONE;
   endtask

   task automatic test_cancel;
      int seen;
      seen = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.src_a = $urandom;
      bus.src_b = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = OP_NONE;
      repeat (9) @(negedge clk);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL cancel_run busy %b want 0", bus.busy);
      end
      for (int j = 0; j < 40; j++) begin
         if (bus.done) seen++;
         @(negedge clk);
      end
      checks++;
      if ({bus.hi, bus.lo, seen} !== {exp_hi, exp_lo, 32'd0}) begin
         errors++;
         $display("FAIL cancel_keep got hi %h lo %h dones %0d want %h %h 0",
                  bus.hi, bus.lo, seen, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset_mid;
      int lat, bad;
      logic [63:0] want;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.src_a = 32'h7;
      bus.src_b = 32'h9;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = OP_NONE;
      repeat (15) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.hi, bus.lo, bus.busy, bus.stall, bus.done} !== 67'd0) begin
         errors++;
         $display("FAIL reset_mid got hi %h lo %h flags %b want all 0",
                  bus.hi, bus.lo, {bus.busy, bus.stall, bus.done});
      end
      @(negedge clk);
      reset = 1'b1;
      want = model(OP_DIVU, 32'd1000, 32'd33);
      issue(OP_DIVU, 32'd1000, 32'd33, lat, bad);
      checks++;
      if ({bus.hi, bus.lo} !== want || lat !== 33) begin
         errors++;
         $display("FAIL after_reset got %h%h lat %0d want %h lat 33",
                  bus.hi, bus.lo, lat, want);
      end
      exp_hi = want[63:32];
      exp_lo = want[31:0];
   endtask

   task automatic test_back_to_back;
      int lat1, lat2;
      logic [31:0] a1, b1, a2, b2;
      logic [63:0] w1, w2, got1;
      logic st;
      lat1 = -1;
      lat2 = -1;
      st   = 1'b0;
      a1 = $urandom;
      b1 = $urandom;
      a2 = $urandom;
      b2 = $urandom;
      w1 = model(OP_MULT, a1, b1);
      w2 = model(OP_MULT, a2, b2);
      got1 = 64'd0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.src_a = a1;
      bus.src_b = b1;
      @(negedge clk);
      bus.src_a = a2;
      bus.src_b = b2;
      for (int j = 0; j < 40; j++) begin
         if (bus.done) begin
            lat1 = j;
            got1 = {bus.hi, bus.lo};
            st   = bus.stall;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (got1 !== w1 || lat1 !== 33 || st !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first got %h lat %0d stall %b want %h 33 1",
                  got1, lat1, st, w1);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = OP_NONE;
      for (int j = 0; j < 40; j++) begin
         if (bus.done) begin
            lat2 = j;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if ({bus.hi, bus.lo} !== w2 || lat2 !== 33) begin
         errors++;
         $display("FAIL b2b_second got %h%h lat %0d want %h 33",
                  bus.hi, bus.lo, lat2, w2);
      end
      exp_hi = w2[63:32];
      exp_lo = w2[31:0];
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      bus.start  = 1'b0;
      bus.op     = OP_NONE;
      bus.src_a  = '0;
      bus.src_b  = '0;
      bus.cancel = 1'b0;
      test_reset();
      test_mult_vec();
      test_div_vec();
      test_div_corner();
      test_move();
      test_idle_ignore();
      test_random();
      test_cancel();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
